// File: rtl/pipelined_adder_tree_pkg.sv
// ============================================================================
// Module : adder_tree_pkg
// Brief  : Shared helpers for the pipelined signed adder tree (widths,
//          level sizing, register placement, latency, saturating narrow).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_tree_pkg;

    // Tree arithmetic width: one growth bit per reduction level.
    function automatic int tree_width(input int iwidth, input int ninputs);
        return iwidth + $clog2(ninputs);
    endfunction

    // Number of live elements after k reduction levels.
    function automatic int level_count(input int ninputs, input int k);
        int c;
        c = ninputs;
        for (int i = 0; i < k; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // The last level is always registered so the tree output is a clean flop.
    function automatic bit level_registered(input int k, input int nstages, input int reg_every);
        if (reg_every <= 0) begin
            return 1'b0;
        end
        return ((k % reg_every) == 0) || (k == nstages);
    endfunction

    function automatic int tree_latency(input int ninputs, input int reg_every);
        int nst;
        nst = $clog2(ninputs);
        if (reg_every <= 0) begin
            return 0;
        end
        return (nst + reg_every - 1) / reg_every;
    endfunction

    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_adder_tree_if.sv
// ============================================================================
// Module : pipelined_adder_tree_if
// Brief  : Beat stream in (data + first/last sideband), packet result out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface pipelined_adder_tree_if #(
    parameter int NINPUTS = 27,
    parameter int IWIDTH  = 8,
    parameter int OWIDTH  = 18
);
    logic                     in_valid;
    logic                     in_first;
    logic                     in_last;
    logic signed [IWIDTH-1:0] d [NINPUTS];
    logic                     out_valid;
    logic signed [OWIDTH-1:0] q;

    modport master (
        output in_valid, in_first, in_last, d,
        input  out_valid, q
    );

    modport slave (
        input  in_valid, in_first, in_last, d,
        output out_valid, q
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_adder_tree_level.sv
// ============================================================================
// Module : adder_tree_level
// Brief  : One pairwise reduction level with optional output register;
//          valid/first/last travel alongside the data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_tree_level #(
    parameter int  NIN        = 2,
    parameter int  WIDTH      = 8,
    parameter bit  REGISTERED = 1'b1,
    localparam int c_nout     = (NIN + 1) / 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_valid,
    input  wire logic                    i_first,
    input  wire logic                    i_last,
    input  wire logic signed [WIDTH-1:0] i_data [NIN],
    output logic                         o_valid,
    output logic                         o_first,
    output logic                         o_last,
    output logic signed [WIDTH-1:0]      o_data [c_nout]
);

    logic signed [WIDTH-1:0] w_sum [c_nout];

    for (genvar j = 0; j < NIN / 2; j++) begin : g_pair
        assign w_sum[j] = i_data[2*j] + i_data[2*j+1];
    end

    if ((NIN % 2) != 0) begin : g_odd
        assign w_sum[c_nout-1] = i_data[NIN-1];
    end

    if (REGISTERED) begin : g_reg
        logic signed [WIDTH-1:0] r_data [c_nout];
        logic                    r_valid;
        logic                    r_first;
        logic                    r_last;

        // Data is don't-care while valid is low, so it needs no reset.
        always_ff @(posedge clk) begin
            r_data <= w_sum;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_valid <= i_valid;
                r_first <= i_first;
                r_last  <= i_last;
            end
        end

        assign o_data  = r_data;
        assign o_valid = r_valid;
        assign o_first = r_first;
        assign o_last  = r_last;
    end else begin : g_comb
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign o_data   = w_sum;
        assign o_valid  = i_valid;
        assign o_first  = i_first;
        assign o_last   = i_last;
    end

endmodule

`default_nettype wire

// File: rtl/pipelined_adder_tree.sv
// ============================================================================
// Module : pipelined_adder_tree
// Brief  : Streaming signed reduction tree plus per-packet accumulator.
//          Define PIPELINED_ADDER_TREE_SAT_EN to saturate the output narrowing
//          instead of truncating.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int NINPUTS   = 27,
    parameter int IWIDTH    = 8,
    parameter int OWIDTH    = 18,
    parameter int AWIDTH    = 24,
    parameter int REG_EVERY = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    pipelined_adder_tree_if.slave bus
);

    localparam int c_nstages = $clog2(NINPUTS);
    localparam int c_swidth  = tree_width(IWIDTH, NINPUTS);

    // Level 0 is the sign-extended input; level k reduces level k-1.
    for (genvar k = 0; k <= c_nstages; k++) begin : g_lvl
        localparam int c_cnt = level_count(NINPUTS, k);

        logic signed [c_swidth-1:0] w_data [c_cnt];
        logic                       w_valid;
        logic                       w_first;
        logic                       w_last;

        if (k == 0) begin : g_src
            for (genvar i = 0; i < NINPUTS; i++) begin : g_ext
                assign w_data[i] = c_swidth'(bus.d[i]);
            end
            assign w_valid = bus.in_valid;
            assign w_first = bus.in_first;
            assign w_last  = bus.in_last;
        end else begin : g_red
            adder_tree_level #(
                .NIN        (level_count(NINPUTS, k - 1)),
                .WIDTH      (c_swidth),
                .REGISTERED (level_registered(k, c_nstages, REG_EVERY))
            ) u_level (
                .clk     (clk),
                .rst     (rst),
                .i_valid (g_lvl[k-1].w_valid),
                .i_first (g_lvl[k-1].w_first),
                .i_last  (g_lvl[k-1].w_last),
                .i_data  (g_lvl[k-1].w_data),
                .o_valid (w_valid),
                .o_first (w_first),
                .o_last  (w_last),
                .o_data  (w_data)
            );
        end
    end

    logic signed [c_swidth-1:0] w_sum;
    logic                       w_valid;
    logic                       w_first;
    logic                       w_last;
    logic signed [AWIDTH-1:0]   w_acc_next;
    logic signed [OWIDTH-1:0]   w_q_next;

    logic signed [AWIDTH-1:0]   r_acc;
    logic signed [OWIDTH-1:0]   r_q;
    logic                       r_out_valid;

    assign w_sum   = g_lvl[c_nstages].w_data[0];
    assign w_valid = g_lvl[c_nstages].w_valid;
    assign w_first = g_lvl[c_nstages].w_first;
    assign w_last  = g_lvl[c_nstages].w_last;

    // A first beat restarts the packet, dropping any unterminated partial sum.
    always_comb begin
        w_acc_next = w_first ? AWIDTH'(w_sum) : (r_acc + AWIDTH'(w_sum));
    end

`ifdef PIPELINED_ADDER_TREE_SAT_EN
    assign w_q_next = OWIDTH'(sat_narrow(64'(w_acc_next), OWIDTH));
`else
    assign w_q_next = w_acc_next[OWIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_q         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_valid && w_last;
            if (w_valid) begin
                r_acc <= w_acc_next;
                if (w_last) begin
                    r_q <= w_q_next;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.q         = r_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder_tree.sv
// ============================================================================
// Module : tb_pipelined_adder_tree
// Brief  : Two tree configurations (defaults; OWIDTH=12 with REG_EVERY=2)
//          driven by one stream and compared each cycle against a packet model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_adder_tree;

    localparam int c_n = 27;

    typedef struct {
        int     due;
        longint val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    exp_t   q0[$];
    exp_t   q1[$];
    longint macc;
    longint held0;
    longint held1;

    pipelined_adder_tree_if #(.NINPUTS(c_n), .IWIDTH(8), .OWIDTH(18)) bus0 ();
    pipelined_adder_tree_if #(.NINPUTS(c_n), .IWIDTH(8), .OWIDTH(12)) bus1 ();

    assign bus1.in_valid = bus0.in_valid;
    assign bus1.in_first = bus0.in_first;
    assign bus1.in_last  = bus0.in_last;
    assign bus1.d        = bus0.d;

    pipelined_adder_tree #(
        .NINPUTS(c_n), .IWIDTH(8), .OWIDTH(18), .AWIDTH(24), .REG_EVERY(1)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pipelined_adder_tree #(
        .NINPUTS(c_n), .IWIDTH(8), .OWIDTH(12), .AWIDTH(24), .REG_EVERY(2)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    function automatic longint narrow(input longint v, input int w);
        longint hi;
        hi = (longint'(1) << (w - 1)) - 1;
`ifdef PIPELINED_ADDER_TREE_SAT_EN
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
`else
        return wrapw(v, w);
`endif
    endfunction

    // Packet model: plain sums, 24-bit wrap accumulator, fixed latencies 6 and 4.
    always @(posedge clk) begin
        longint s;
        cyc = cyc + 1;
        if (rst) begin
            macc = 0;
            q0.delete();
            q1.delete();
        end else if (bus0.in_valid === 1'b1) begin
            s = 0;
            for (int i = 0; i < c_n; i++) s = s + longint'(bus0.d[i]);
            macc = bus0.in_first ? s : wrapw(macc + s, 24);
            if (bus0.in_last) begin
                q0.push_back('{cyc + 5, narrow(macc, 18)});
                q1.push_back('{cyc + 3, narrow(macc, 12)});
            end
        end
    end

    task automatic chk_out(input string nm, input logic ov, input longint qv,
                           input bit due, input longint ev);
        n_cmp++;
        if (ov !== due || qv != ev) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: out_valid=%b q=%0d, required out_valid=%0b q=%0d",
                     nm, cyc, ov, qv, due, ev);
        end
    endtask

    always @(negedge clk) begin
        bit due0;
        bit due1;
        if (rst) begin
            q0.delete();
            q1.delete();
            held0 = 0;
            held1 = 0;
            chk_out("reset0", bus0.out_valid, longint'(bus0.q), 1'b0, 0);
            chk_out("reset1", bus1.out_valid, longint'(bus1.q), 1'b0, 0);
        end else begin
            due0 = (q0.size() > 0) && (q0[0].due == cyc);
            due1 = (q1.size() > 0) && (q1[0].due == cyc);
            if (due0) begin
                held0 = q0[0].val;
                void'(q0.pop_front());
            end
            if (due1) begin
                held1 = q1[0].val;
                void'(q1.pop_front());
            end
            chk_out("stream0", bus0.out_valid, longint'(bus0.q), due0, held0);
            chk_out("stream1", bus1.out_valid, longint'(bus1.q), due1, held1);
        end
    end

    task automatic drive(input bit v, input bit f, input bit l, input int val);
        bus0.in_valid = v;
        bus0.in_first = f;
        bus0.in_last  = l;
        for (int i = 0; i < c_n; i++) bus0.d[i] = 8'(val);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus0.in_valid = 1'b0;
        bus0.in_first = 1'b0;
        bus0.in_last  = 1'b0;
    endtask

    // Literal pins: wait for a pulse on one DUT, check its latency and value.
    task automatic wait_pulse(input string nm, input bit which, input int p,
                              input int exp_lat, input longint exp_q);
        logic   ov;
        longint qv;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            ov = which ? bus1.out_valid : bus0.out_valid;
            qv = which ? longint'(bus1.q) : longint'(bus0.q);
            if (ov === 1'b1) begin
                n_cmp++;
                if ((cyc - p + 1) != exp_lat || qv != exp_q) begin
                    n_bad++;
                    $display("FAIL %s: latency=%0d q=%0d, required latency=%0d q=%0d",
                             nm, cyc - p + 1, qv, exp_lat, exp_q);
                end
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no out_valid within 20 cycles, required q=%0d", nm, exp_q);
    endtask

    initial begin
        int p;
        int v;
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        macc  = 0;
        held0 = 0;
        held1 = 0;
        rst   = 1'b1;
        idle();
        for (int i = 0; i < c_n; i++) bus0.d[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        drive(1, 1, 1, 1); p = cyc; idle();
        wait_pulse("ones_re2", 1, p, 4, 27);
        wait_pulse("ones", 0, p, 6, 27);

        drive(1, 1, 1, -128); p = cyc; idle();
`ifdef PIPELINED_ADDER_TREE_SAT_EN
        wait_pulse("neg_ow12", 1, p, 4, -2048);
`else
        wait_pulse("neg_ow12", 1, p, 4, 640);
`endif
        wait_pulse("neg128", 0, p, 6, -3456);

        drive(1, 1, 0, 127);
        drive(1, 0, 0, 127);
        idle();
        @(posedge clk); #1;
        drive(1, 0, 1, 127); p = cyc; idle();
`ifdef PIPELINED_ADDER_TREE_SAT_EN
        wait_pulse("three_ow12", 1, p, 4, 2047);
`else
        wait_pulse("three_ow12", 1, p, 4, -2001);
`endif
        wait_pulse("three_beat", 0, p, 6, 10287);

        drive(1, 1, 1, 127); p = cyc; idle();
`ifdef PIPELINED_ADDER_TREE_SAT_EN
        wait_pulse("ow12_127", 1, p, 4, 2047);
`else
        wait_pulse("ow12_127", 1, p, 4, -667);
`endif
        wait_pulse("max127", 0, p, 6, 3429);

        drive(1, 1, 1, 1); p = cyc;
        drive(1, 1, 1, 2); idle();
        wait_pulse("b2b_a_re2", 1, p, 4, 27);
        wait_pulse("b2b_b_re2", 1, p, 5, 54);
        wait_pulse("b2b_a", 0, p, 6, 27);
        wait_pulse("b2b_b", 0, p, 7, 54);

        drive(1, 1, 0, 5);
        drive(1, 0, 0, 5);
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 1, 1, 1); p = cyc; idle();
        wait_pulse("post_rst_re2", 1, p, 4, 27);
        wait_pulse("post_rst", 0, p, 6, 27);

        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst = 1'b1;
                idle();
                @(posedge clk); #1;
                rst = 1'b0;
            end
            bus0.in_valid = ($urandom_range(0, 9) < 7);
            bus0.in_first = ($urandom_range(0, 3) == 0);
            bus0.in_last  = ($urandom_range(0, 3) == 0);
            v = $urandom_range(0, 7);
            for (int i = 0; i < c_n; i++) begin
                if (v == 0)      bus0.d[i] = 8'sd127;
                else if (v == 1) bus0.d[i] = -8'sd128;
                else             bus0.d[i] = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
        end
        idle();
        repeat (12) @(posedge clk);
        #1;

        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending results dut0=%0d dut1=%0d, required 0 0",
                     q0.size(), q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/pipelined_adder_tree.md
# pipelined_adder_tree

Streaming, pipelined signed reduction tree for the convolution datapath. It sums `NINPUTS` signed products per beat through a binary tree with configurable register insertion. It then accumulates tree results across a multi-beat packet delimited by first/last flags, for example successive input-channel groups of one output pixel. One result is emitted per packet, with the sideband flags carried in lockstep through the pipeline.

## Interface
Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.

Parameters:
- `NINPUTS`, 27: operands per beat.
- `IWIDTH`, 8: signed operand width.
- `OWIDTH`, 18: signed result width.
- `AWIDTH`, 24: signed accumulator width; must be ≥ `SWIDTH`.
- `REG_EVERY`, 1: pipeline register after every `REG_EVERY` tree levels; 0 gives a fully combinational tree.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `in_valid`  in  1  beat present this cycle.
- `in_first`  in  1  first beat of packet; qualified by `in_valid`.
- `in_last`  in  1  last beat of packet; qualified by `in_valid`.
- `d`  in  `NINPUTS` × `IWIDTH`  signed operands, unpacked array.
- `out_valid`  out  1  one-cycle pulse: `q` holds a packet result.
- `q`  out  `OWIDTH`  signed packet sum.

## Operation
- Derived widths:
  - `NSTAGES = $clog2(NINPUTS)`.
  - `SWIDTH = IWIDTH + NSTAGES`.
  - All tree arithmetic is sign-extended to `SWIDTH`; no overflow inside the tree.
- Tree level k:
  - Pairs elements 2j and 2j+1 of level k-1.
  - An odd leftover element passes through unchanged.
- Registers:
  - A level is registered when `REG_EVERY > 0` and (k mod `REG_EVERY` == 0 or k == `NSTAGES`).
  - `valid`, `first` and `last` are delayed by the same register count as the data.
- Accumulator, on a tree-output beat with valid set:
  - When `first` is set, `acc ← sum`. This discards any unterminated partial sum.
  - Otherwise `acc ← acc + sum`, computed in `AWIDTH` with wrap-around.
  - When `last` is set, the registered output takes the new acc value and `out_valid` pulses for 1 cycle.
- `first` and `last` on the same beat form a single-beat packet; the result is that beat's sum.
- A beat with neither flag before any `first` accumulates onto the current acc (0 after reset).
- Beats without `in_valid` leave the accumulator untouched. Gaps inside a packet are allowed.
- Output narrowing from `AWIDTH` to `OWIDTH` follows `## Configuration`.

## Timing
- Tree latency:
  - `L_TREE = ceil(NSTAGES/REG_EVERY)` when `REG_EVERY > 0`, else 0.
  - Total latency from the last beat's `in_valid` to `out_valid` is `L_TREE + 1`.
  - Defaults (`NINPUTS` = 27, `REG_EVERY` = 1): 5 + 1 = 6 cycles.
- Throughput: full rate, one beat per cycle. No backpressure; back-to-back packets are allowed, and the next packet's `first` may follow the previous `last` in the next cycle.
- Reset values: `out_valid` = 0, `q` = 0, acc = 0, all pipeline valid/first/last = 0. Data registers are not reset (don't-care).
- Reset mid-packet: in-flight beats are lost and no `out_valid` is produced for them. The first packet after reset must start with `first`.
- `q` holds its value between pulses.

## Configuration
- `PIPELINED_ADDER_TREE_SAT_EN` defined: narrowing saturates to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
- Undefined: narrowing truncates to the low `OWIDTH` bits, giving two's-complement wrap.
- The macro affects only the output narrowing stage; latency is unchanged.

## Structure
- Package `adder_tree_pkg` holds:
  - a `tree_latency(ninputs, reg_every)` function;
  - a `sat_narrow` function, parametrised through the width argument;
  - the `SWIDTH` derivation helper.
- Sub-module `adder_tree_level`: one reduction level with a parameter for input count and a registered/combinational select. It carries data plus valid/first/last. The top generates `NSTAGES` instances and adds the accumulator/output stage.

## Test plan
- All `d` = 1, `in_first` = `in_last` = 1, defaults → `out_valid` at cycle +6, `q` = 27.
- All `d` = -128, single-beat packet → `q` = -3456.
- Three-beat packet, all `d` = 127, with one idle cycle between beats 2 and 3 → single pulse, `q` = 10287.
- `OWIDTH` = 12, all `d` = 127, single beat:
  - macro defined → `q` = 2047;
  - undefined → `q` = -667.
- `REG_EVERY` = 2, back-to-back single-beat packets with `d` = 1 and then `d` = 2 → pulses at cycles +4 and +5, `q` = 27 then 54.
- `rst` asserted after beat 2 of a 3-beat packet, then a fresh packet of one beat with `d` = 1 → no pulse for the aborted packet; next result `q` = 27.
